// File: rtl/pinv_fixed_pkg.sv
// Shared Q17.15 fixed-point types and helpers for the pseudoinverse datapath.
// Optional macro DOT_SATURATE_EN: out-of-range words clamp instead of wrapping.
package pinv_fixed_pkg;

  localparam int FRAC_BITS = 15;
  localparam int WORD_W    = 32;

  typedef logic signed [WORD_W-1:0] fixed_t;

  localparam fixed_t FIX_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIX_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } dot_state_t;

  // True when a wide intermediate is representable as a signed word.
  function automatic logic fits_word(input logic signed [2*WORD_W-1:0] v);
    return (v[2*WORD_W-1:WORD_W-1] == {(WORD_W+1){v[WORD_W-1]}});
  endfunction

  function automatic fixed_t reduce_word(input logic signed [2*WORD_W-1:0] v);
`ifdef DOT_SATURATE_EN
    if (!fits_word(v)) return v[2*WORD_W-1] ? FIX_MIN : FIX_MAX;
`endif
    return v[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/fixed_mult.sv
// Two-stage pipelined Q17.15 multiplier: operand register, then full-product register.
// Reduced result and overflow are derived combinationally from the product register.
module fixed_mult
  import pinv_fixed_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  fixed_t                    a,
  input  fixed_t                    b,
  output logic signed [2*WORD_W-1:0] prod,
  output fixed_t                    res,
  output logic                      ovf
);

  fixed_t a_q, b_q;
  logic signed [2*WORD_W-1:0] a_ext, b_ext, shifted;

  assign a_ext = {{WORD_W{a_q[WORD_W-1]}}, a_q};
  assign b_ext = {{WORD_W{b_q[WORD_W-1]}}, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      prod <= '0;
    end else if (ce) begin
      a_q  <= a;
      b_q  <= b;
      prod <= a_ext * b_ext;
    end
  end

  // Arithmetic shift truncates toward minus infinity.
  assign shifted = prod >>> FRAC_BITS;
  assign ovf     = !fits_word(shifted);
  assign res     = reduce_word(shifted);

endmodule

// File: rtl/dot_accumulator.sv
// Streaming Q17.15 inner-product engine: len operand pairs in, one accumulated word out.
// Optional macro DOT_SATURATE_EN selects clamping instead of two's-complement wrap.
module dot_accumulator
  import pinv_fixed_pkg::*;
#(
  parameter int LEN_W    = 7,
  parameter int PIPE_MUL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  fixed_t           a,
  input  fixed_t           b,
  output logic             out_valid,
  input  logic             out_ready,
  output fixed_t           s,
  output logic             busy,
  output logic             ovf
);

  if (PIPE_MUL != 2) begin : g_pipe_check
    $error("dot_accumulator supports only PIPE_MUL == 2");
  end

  dot_state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt, cnt_inc;
  logic v1, v2, ovf_q;
  fixed_t acc, mul_res;
  logic mul_ovf, add_ovf;
  logic signed [2*WORD_W-1:0] mul_prod, sum_ext;
  logic unused_prod;

  fixed_mult u_mult (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .a    (a),
    .b    (b),
    .prod (mul_prod),
    .res  (mul_res),
    .ovf  (mul_ovf)
  );

  assign unused_prod = ^mul_prod;
  assign cnt_inc     = cnt + LEN_W'(1);
  assign sum_ext     = {{WORD_W{acc[WORD_W-1]}}, acc} + {{WORD_W{mul_res[WORD_W-1]}}, mul_res};
  assign add_ovf     = !fits_word(sum_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else if (ce) state_q <= state_d;
  end

  // DRAIN ends once stage 1 is empty: the stage-2 product lands in acc on that same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN:     if (in_valid && (cnt_inc == len_q)) state_d = DRAIN;
      DRAIN:   if (!v1) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (ce) begin
      v1 <= in_valid && (state_q == RUN);
      v2 <= v1;
      if ((state_q == IDLE) && start) begin
        cnt   <= '0;
        len_q <= len;
        acc   <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (in_valid && (state_q == RUN)) cnt <= cnt_inc;
        if (v2) begin
          acc <= reduce_word(sum_ext);
          if (mul_ovf || add_ovf) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed self-checking bench for dot_accumulator with hand-computed Q17.15 results.
// Overflow expectations follow DOT_SATURATE_EN when the bench is built with it.
module tb_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic        busy;
  logic        ovf;

  int total = 0;
  int bad = 0;

  dot_accumulator #(.LEN_W(7), .PIPE_MUL(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (s !== 32'h0) begin bad++; $display("[TB] FAIL reset_s got=%h want=00000000", s); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_start(7'd1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_in_ready got=%b want=1", in_ready); end
    send_pair(32'h0001_8000, 32'h0000_8000);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_t1 got=%b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_t2 got=%b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_t3 got=%b want=1", out_valid); end
    total++; if (s !== 32'h0001_8000) begin bad++; $display("[TB] FAIL single_s got=%h want=00018000", s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL single_ovf got=%b want=0", ovf); end
    finish_result();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_gapped();
    int n;
    logic [31:0] va [4] = '{32'h0000_8000, 32'hFFFF_4000, 32'h0000_4000, 32'h0001_8000};
    logic [31:0] vb [4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_4000, 32'hFFFF_8000};
    do_start(7'd4);
    for (int i = 0; i < 4; i++) begin
      send_pair(va[i], vb[i]);
      repeat (2) tick();
    end
    wait_done(n);
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL gapped_timeout got=%b want=1", out_valid); end
    total++; if (s !== 32'hFFFE_2000) begin bad++; $display("[TB] FAIL gapped_s got=%h want=fffe2000", s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL gapped_ovf got=%b want=0", ovf); end
    finish_result();
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] want;
`ifdef DOT_SATURATE_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h0001_0000;
`endif
    do_start(7'd2);
    send_pair(32'h7FFF_8000, 32'h7FFF_8000);
    send_pair(32'h7FFF_8000, 32'h7FFF_8000);
    wait_done(n);
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovf_timeout got=%b want=1", out_valid); end
    total++; if (s !== want) begin bad++; $display("[TB] FAIL ovf_s got=%h want=%h", s, want); end
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", ovf); end
    finish_result();
  endtask

  task automatic test_done_hold();
    int n;
    do_start(7'd1);
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL hold_ovf_cleared got=%b want=0", ovf); end
    send_pair(32'h0001_0000, 32'h0000_4000);
    wait_done(n);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 7'd3;
      tick();
      start = 1'b0;
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || s !== 32'h0000_8000) begin
        bad++;
        $display("[TB] FAIL hold_cycle%0d got ov=%b busy=%b s=%h want ov=1 busy=1 s=00008000", i, out_valid, busy, s);
      end
    end
    start = 1'b1;
    len = 7'd0;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL hold_release got ov=%b busy=%b want ov=0 busy=0", out_valid, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL hold_start_ignored got=%b want=0", busy); end
  endtask

  task automatic test_ce_stall();
    do_start(7'd2);
    send_pair(32'h0000_8000, 32'h0001_0000);
    ce = 1'b0;
    a = 32'h0000_4000;
    b = 32'h0000_4000;
    in_valid = 1'b1;
    repeat (3) tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_run_hold got=%b want=1", in_ready); end
    ce = 1'b1;
    tick();
    in_valid = 1'b0;
    ce = 1'b0;
    repeat (3) tick();
    total++; if (out_valid !== 1'b0 || s !== 32'h0) begin bad++; $display("[TB] FAIL stall_drain_hold got ov=%b s=%h want ov=0 s=00000000", out_valid, s); end
    ce = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || s !== 32'h0001_0000) begin bad++; $display("[TB] FAIL stall_t5 got ov=%b s=%h want ov=0 s=00010000", out_valid, s); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_t6 got=%b want=1", out_valid); end
    total++; if (s !== 32'h0001_2000) begin bad++; $display("[TB] FAIL stall_s got=%h want=00012000", s); end
    finish_result();
  endtask

  task automatic test_reset_midrun();
    do_start(7'd5);
    send_pair(32'h0000_8000, 32'h0000_8000);
    repeat (3) tick();
    total++; if (s !== 32'h0000_8000 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrun_pre got s=%h rdy=%b want s=00008000 rdy=1", s, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || s !== 32'h0 || busy !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrun_reset got rdy=%b ov=%b s=%h busy=%b ovf=%b want all zero", in_ready, out_valid, s, busy, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_start(7'd0);
    total++; if (out_valid !== 1'b1 || s !== 32'h0) begin bad++; $display("[TB] FAIL len0 got ov=%b s=%h want ov=1 s=00000000", out_valid, s); end
    finish_result();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL len0_idle got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_overflow();
    test_done_hold();
    test_ce_stall();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
